// File: rtl/noise_level_ctrl.sv
// noise_level_ctrl: debounced up/down push-buttons step a noise level through LEVEL_TABLE.
// Define NOISE_CTRL_AUTOREPEAT_EN to add hold-to-auto-repeat on both buttons.
module noise_level_ctrl #(
  parameter int unsigned NOISE_MAG_WIDTH = 8,
  parameter int unsigned NUM_LEVELS      = 4,
  parameter logic [NUM_LEVELS*NOISE_MAG_WIDTH-1:0] LEVEL_TABLE = {8'd100, 8'd50, 8'd20, 8'd0},
  parameter int unsigned DEBOUNCE_BITS   = 19,
  parameter bit          BTN_ACTIVE_LOW  = 1'b1,
  parameter bit          WRAP            = 1'b1,
  parameter int unsigned HOLD_CYCLES     = 13500000,
  parameter int unsigned REPEAT_CYCLES   = 5400000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          btn_up,
  input  logic                          btn_dn,
  output logic [$clog2(NUM_LEVELS)-1:0] noise_sel,
  output logic [NOISE_MAG_WIDTH-1:0]    noise_magnitude,
  output logic                          level_changed,
  output logic                          at_min,
  output logic                          at_max
);

  localparam int unsigned      SEL_W        = $clog2(NUM_LEVELS);
  localparam logic [SEL_W-1:0] MAX_SEL      = SEL_W'(NUM_LEVELS - 1);
  localparam logic             RELEASED_RAW = BTN_ACTIVE_LOW;

  logic [1:0]                 btn_raw;
  logic [1:0]                 btn_evt;
  logic [SEL_W-1:0]           sel_nxt;
  logic [NOISE_MAG_WIDTH-1:0] lvl_tab [NUM_LEVELS];

  assign btn_raw = {btn_dn, btn_up};

  for (genvar i = 0; i < NUM_LEVELS; i++) begin : g_tab
    assign lvl_tab[i] = LEVEL_TABLE[i*NOISE_MAG_WIDTH +: NOISE_MAG_WIDTH];
  end

  // Bit 0 = up, bit 1 = down; both buttons share the same sync/debounce/event path.
  for (genvar b = 0; b < 2; b++) begin : g_btn
    logic                     sync1;
    logic                     sync2;
    logic                     pressed;
    logic                     stable;
    logic                     stable_d;
    logic                     press_evt;
    logic [DEBOUNCE_BITS-1:0] db_cnt;

    assign pressed   = sync2 ^ RELEASED_RAW;
    assign press_evt = stable & ~stable_d;

    always_ff @(posedge clk) begin
      if (rst) begin
        sync1    <= RELEASED_RAW;
        sync2    <= RELEASED_RAW;
        stable   <= 1'b0;
        stable_d <= 1'b0;
        db_cnt   <= '0;
      end else begin
        sync1    <= btn_raw[b];
        sync2    <= sync1;
        stable_d <= stable;
        if (pressed == stable) begin
          db_cnt <= '0;
        end else if (db_cnt == '1) begin
          stable <= pressed;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + DEBOUNCE_BITS'(1);
        end
      end
    end

`ifdef NOISE_CTRL_AUTOREPEAT_EN
    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);

    logic [HOLD_W-1:0] hold_cnt;
    logic              rep_evt;

    assign rep_evt = stable & (hold_cnt == HOLD_W'(HOLD_CYCLES - 1));

    // Reload lands REPEAT_CYCLES short of the fire point, so later repeats come faster.
    always_ff @(posedge clk) begin
      if (rst || press_evt || !stable) begin
        hold_cnt <= '0;
      end else if (rep_evt) begin
        hold_cnt <= HOLD_W'(HOLD_CYCLES - REPEAT_CYCLES);
      end else begin
        hold_cnt <= hold_cnt + HOLD_W'(1);
      end
    end

    assign btn_evt[b] = press_evt | rep_evt;
`else
    assign btn_evt[b] = press_evt;
`endif
  end

  // Simultaneous up and down events cancel.
  always_comb begin
    sel_nxt = noise_sel;
    if (btn_evt == 2'b01) begin
      if (noise_sel < MAX_SEL) begin
        sel_nxt = noise_sel + SEL_W'(1);
      end else if (WRAP) begin
        sel_nxt = '0;
      end
    end else if (btn_evt == 2'b10) begin
      if (noise_sel != '0) begin
        sel_nxt = noise_sel - SEL_W'(1);
      end else if (WRAP) begin
        sel_nxt = MAX_SEL;
      end
    end
  end

  // All outputs derive from sel_nxt so they move together on one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      noise_sel       <= '0;
      noise_magnitude <= lvl_tab[0];
      level_changed   <= 1'b0;
      at_min          <= 1'b1;
      at_max          <= 1'b0;
    end else begin
      noise_sel       <= sel_nxt;
      noise_magnitude <= lvl_tab[sel_nxt];
      level_changed   <= (sel_nxt != noise_sel);
      at_min          <= (sel_nxt == '0);
      at_max          <= (sel_nxt == MAX_SEL);
    end
  end

endmodule

// File: tb/tb_noise_level_ctrl.sv
// Scoreboard bench for noise_level_ctrl: a wrapping DUT and a saturating DUT, DEBOUNCE_BITS=3.
// Expectations adapt to NOISE_CTRL_AUTOREPEAT_EN (HOLD_CYCLES=16, REPEAT_CYCLES=4).
module tb_noise_level_ctrl;

  typedef struct {
    int cyc;
    int sel;
    int mag;
    bit amin;
    bit amax;
  } exp_t;

  logic       clk    = 1'b0;
  logic       rst    = 1'b1;
  logic       btn_up = 1'b1;
  logic       btn_dn = 1'b1;
  logic       sat_en = 1'b0;
  logic       sat_up;
  logic [1:0] sel_m, sel_s;
  logic [7:0] mag_m, mag_s;
  logic       lc_m, lc_s, amin_m, amin_s, amax_m, amax_s;

  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  exp_t q_m[$];
  exp_t q_s[$];

  assign sat_up = sat_en ? btn_up : 1'b1;

  always #5 clk = ~clk;

  noise_level_ctrl #(
    .DEBOUNCE_BITS(3), .WRAP(1'b1), .HOLD_CYCLES(16), .REPEAT_CYCLES(4)
  ) u_wrap (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_dn(btn_dn),
    .noise_sel(sel_m), .noise_magnitude(mag_m), .level_changed(lc_m),
    .at_min(amin_m), .at_max(amax_m)
  );

  noise_level_ctrl #(
    .DEBOUNCE_BITS(3), .WRAP(1'b0), .HOLD_CYCLES(16), .REPEAT_CYCLES(4)
  ) u_sat (
    .clk(clk), .rst(rst), .btn_up(sat_up), .btn_dn(1'b1),
    .noise_sel(sel_s), .noise_magnitude(mag_s), .level_changed(lc_s),
    .at_min(amin_s), .at_max(amax_s)
  );

  function automatic int mag_of(input int s);
    case (s)
      0:       return 0;
      1:       return 20;
      2:       return 50;
      default: return 100;
    endcase
  endfunction

  task automatic push(input bit sat, input int c, input int s);
    exp_t e;
    e.cyc  = c;
    e.sel  = s;
    e.mag  = mag_of(s);
    e.amin = (s == 0);
    e.amax = (s == 3);
    if (sat) q_s.push_back(e);
    else     q_m.push_back(e);
  endtask

  task automatic chk(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cyc=%0d)", nm, got, want, cyc);
    end
  endtask

  // Monitor: a level_changed pulse is the DUT's "output valid".
  task automatic mon(input bit sat, input logic lc, input logic [1:0] s, input logic [7:0] m,
                     input logic amn, input logic amx);
    exp_t  e;
    bit    have;
    string nm;
    nm   = sat ? "sat" : "wrap";
    have = sat ? (q_s.size() != 0) : (q_m.size() != 0);
    if (have) e = sat ? q_s[0] : q_m[0];
    if (have && e.cyc < cyc) begin
      total++;
      bad++;
      $display("FAIL %s_missed_pulse: no level_changed for sel=%0d at cyc=%0d", nm, e.sel, e.cyc);
      if (sat) void'(q_s.pop_front());
      else     void'(q_m.pop_front());
    end else if (lc) begin
      total++;
      if (!have) begin
        bad++;
        $display("FAIL %s_unexpected_pulse: got sel=%0d mag=%0d at cyc=%0d, want no pulse",
                 nm, s, m, cyc);
      end else begin
        if (sat) void'(q_s.pop_front());
        else     void'(q_m.pop_front());
        if (e.cyc != cyc || e.sel != int'(s) || e.mag != int'(m) ||
            e.amin != amn || e.amax != amx) begin
          bad++;
          $display("FAIL %s_step: got cyc=%0d sel=%0d mag=%0d min=%0b max=%0b want cyc=%0d sel=%0d mag=%0d min=%0b max=%0b",
                   nm, cyc, s, m, amn, amx, e.cyc, e.sel, e.mag, e.amin, e.amax);
        end
      end
    end
  endtask

  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    mon(1'b0, lc_m, sel_m, mag_m, amin_m, amax_m);
    mon(1'b1, lc_s, sel_s, mag_s, amin_s, amax_s);
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ms/ss: expected new level on the wrap/sat DUT, or -1 for no pulse.
  task automatic press(input bit up, input bit dn, input int ms, input int ss);
    int n0;
    @(negedge clk);
    btn_up = ~up;
    btn_dn = ~dn;
    n0 = cyc;
    if (ms >= 0) push(1'b0, n0 + 11, ms);
    if (ss >= 0) push(1'b1, n0 + 11, ss);
    idle(12);
    btn_up = 1'b1;
    btn_dn = 1'b1;
    idle(14);
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int d;
    int p;
    idle(3);
    rst = 1'b0;
    chk("rst_sel", int'(sel_m), 0);
    chk("rst_mag", int'(mag_m), 0);
    chk("rst_lc", int'(lc_m), 0);
    chk("rst_at_min", int'(amin_m), 1);
    chk("rst_at_max", int'(amax_m), 0);
    chk("rst_sat_sel", int'(sel_s), 0);

    // First press: step 0->1 eleven edges after the button falls.
    press(1'b1, 1'b0, 1, -1);

    // Six-cycle glitch must not register.
    @(negedge clk);
    btn_up = 1'b0;
    idle(6);
    btn_up = 1'b1;
    idle(20);
    chk("glitch_sel", int'(sel_m), 1);

    // Wrap versus saturate over four up presses.
    pulse_rst();
    chk("rst2_sel", int'(sel_m), 0);
    sat_en = 1'b1;
    press(1'b1, 1'b0, 1, 1);
    press(1'b1, 1'b0, 2, 2);
    press(1'b1, 1'b0, 3, 3);
    press(1'b1, 1'b0, 0, -1);
    sat_en = 1'b0;
    chk("sat_hold_sel", int'(sel_s), 3);
    chk("sat_hold_mag", int'(mag_s), 100);
    chk("sat_at_max", int'(amax_s), 1);
    chk("wrap_at_min", int'(amin_m), 1);

    // Simultaneous up+down cancels; down alone then steps.
    press(1'b1, 1'b0, 1, -1);
    press(1'b1, 1'b0, 2, -1);
    press(1'b1, 1'b1, -1, -1);
    chk("both_sel", int'(sel_m), 2);
    press(1'b0, 1'b1, 1, -1);
    chk("dn_mag", int'(mag_m), 20);

    // Reset mid-debounce with down still held.
    press(1'b1, 1'b0, 2, -1);
    press(1'b1, 1'b0, 3, -1);
    @(negedge clk);
    btn_dn = 1'b0;
    idle(5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    d = cyc;
    push(1'b0, d + 11, 3);
    chk("mid_rst_sel", int'(sel_m), 0);
    chk("mid_rst_mag", int'(mag_m), 0);
    chk("mid_rst_at_min", int'(amin_m), 1);
    idle(12);
    btn_dn = 1'b1;
    idle(14);

    // Long hold on up.
    @(negedge clk);
    btn_up = 1'b0;
    p = cyc + 11;
    push(1'b0, p, 0);
`ifdef NOISE_CTRL_AUTOREPEAT_EN
    push(1'b0, p + 16, 1);
    push(1'b0, p + 20, 2);
    push(1'b0, p + 24, 3);
    push(1'b0, p + 28, 0);
    push(1'b0, p + 32, 1);
    push(1'b0, p + 36, 2);
`endif
    idle(39);
    btn_up = 1'b1;
    idle(40);
`ifdef NOISE_CTRL_AUTOREPEAT_EN
    chk("hold_final_sel", int'(sel_m), 2);
`else
    chk("hold_final_sel", int'(sel_m), 0);
`endif
    chk("wrap_q_drained", q_m.size(), 0);
    chk("sat_q_drained", q_s.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
